// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer: opcodes, FSM states,
// ALU op classes, trap causes and instruction-class bit positions.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] TC_NONE    = 2'b00;
    localparam logic [1:0] TC_ILLEGAL = 2'b01;
    localparam logic [1:0] TC_TIMEOUT = 2'b10;

    localparam int CLS_R       = 0;
    localparam int CLS_I       = 1;
    localparam int CLS_LOAD    = 2;
    localparam int CLS_STORE   = 3;
    localparam int CLS_BRANCH  = 4;
    localparam int CLS_ILLEGAL = 5;

endpackage

// File: rtl/instr_class_dec.sv
// Combinational opcode classifier producing a one-hot instruction class
// {illegal, branch, store, load, i, r}.
module instr_class_dec
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [5:0] cls
);

    // One-hot class lookup; anything unrecognised is illegal
    always_comb begin
        cls = 6'b000000;
        case (opcode)
            OP_R:      cls[CLS_R]       = 1'b1;
            OP_I:      cls[CLS_I]       = 1'b1;
            OP_LOAD:   cls[CLS_LOAD]    = 1'b1;
            OP_STORE:  cls[CLS_STORE]   = 1'b1;
            OP_BRANCH: cls[CLS_BRANCH]  = 1'b1;
            default:   cls[CLS_ILLEGAL] = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I subset datapath.
// Define MULTICYCLE_CTRL_PERF_EN to add instret/cycles performance counters.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic        alusrc,
    output logic [1:0]  aluop,
    output logic        regwrite,
    output logic        memtoreg,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  trap_cause
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0] instret,
    output logic [31:0] cycles
`endif
);

    // Counter value whose next increment would reach MEM_TIMEOUT
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_r;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [1:0]       trap_cause_r;
    logic [5:0]       cls_s;

    logic       mem_req_s, mem_we_s, mem_addr_sel_s, ir_we_s, pc_we_s, pc_src_s;
    logic       alusrc_s, regwrite_s, memtoreg_s, retire_s, trap_s;
    logic [1:0] aluop_s;

    instr_class_dec u_dec (
        .opcode (opcode),
        .cls    (cls_s)
    );

    // Sequencer state, memory wait counter and sticky trap cause
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_FETCH;
            wait_cnt_r   <= '0;
            trap_cause_r <= TC_NONE;
        end else begin
            case (state_r)
                S_FETCH, S_MEM: begin
                    if (mem_ready) begin
                        wait_cnt_r <= '0;
                        if (state_r == S_FETCH) begin
                            state_r <= S_DECODE;
                        end else if (cls_s[CLS_LOAD]) begin
                            state_r <= S_WB;
                        end else if (cls_s[CLS_STORE]) begin
                            state_r <= S_FETCH;
                        end else begin
                            state_r      <= S_TRAP;
                            trap_cause_r <= TC_ILLEGAL;
                        end
                    end else if (wait_cnt_r == TIMEOUT_CNT) begin
                        // mem_ready has priority because it is checked first
                        wait_cnt_r   <= wait_cnt_r + 1'b1;
                        state_r      <= S_TRAP;
                        trap_cause_r <= TC_TIMEOUT;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 1'b1;
                    end
                end
                S_DECODE: begin
                    wait_cnt_r <= '0;
                    if (cls_s[CLS_ILLEGAL]) begin
                        state_r      <= S_TRAP;
                        trap_cause_r <= TC_ILLEGAL;
                    end else begin
                        state_r <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    wait_cnt_r <= '0;
                    if (cls_s[CLS_R] || cls_s[CLS_I]) begin
                        state_r <= S_WB;
                    end else if (cls_s[CLS_LOAD] || cls_s[CLS_STORE]) begin
                        state_r <= S_MEM;
                    end else if (cls_s[CLS_BRANCH]) begin
                        state_r <= S_FETCH;
                    end else begin
                        state_r      <= S_TRAP;
                        trap_cause_r <= TC_ILLEGAL;
                    end
                end
                S_WB: begin
                    wait_cnt_r <= '0;
                    state_r    <= S_FETCH;
                end
                S_TRAP: begin
                    state_r <= S_TRAP;
                end
                default: begin
                    state_r      <= S_TRAP;
                    trap_cause_r <= TC_ILLEGAL;
                end
            endcase
        end
    end

    // Datapath strobes decoded from state, instruction class and handshake
    always_comb begin
        mem_req_s      = 1'b0;
        mem_we_s       = 1'b0;
        mem_addr_sel_s = 1'b0;
        ir_we_s        = 1'b0;
        pc_we_s        = 1'b0;
        pc_src_s       = 1'b0;
        alusrc_s       = 1'b0;
        aluop_s        = ALU_ADD;
        regwrite_s     = 1'b0;
        memtoreg_s     = 1'b0;
        retire_s       = 1'b0;
        trap_s         = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_req_s = 1'b1;
                if (mem_ready) begin
                    ir_we_s = 1'b1;
                    pc_we_s = 1'b1;
                end else begin
                    ir_we_s = 1'b0;
                end
            end
            S_EXEC: begin
                if (cls_s[CLS_R]) begin
                    aluop_s = ALU_FUNCT;
                end else if (cls_s[CLS_I]) begin
                    alusrc_s = 1'b1;
                    aluop_s  = ALU_FUNCT;
                end else if (cls_s[CLS_LOAD] || cls_s[CLS_STORE]) begin
                    alusrc_s = 1'b1;
                end else if (cls_s[CLS_BRANCH]) begin
                    aluop_s  = ALU_SUB;
                    pc_we_s  = zero;
                    pc_src_s = zero;
                    retire_s = 1'b1;
                end else begin
                    aluop_s = ALU_ADD;
                end
            end
            S_MEM: begin
                mem_req_s      = 1'b1;
                mem_addr_sel_s = 1'b1;
                alusrc_s       = 1'b1;
                mem_we_s       = cls_s[CLS_STORE];
                retire_s       = mem_ready & cls_s[CLS_STORE];
            end
            S_WB: begin
                regwrite_s = 1'b1;
                memtoreg_s = cls_s[CLS_LOAD];
                retire_s   = 1'b1;
            end
            S_TRAP: begin
                trap_s = 1'b1;
            end
            default: begin
                trap_s = 1'b0;
            end
        endcase
    end

    // Reset forces every output low immediately, independent of the clock
    assign mem_req      = rst_n & mem_req_s;
    assign mem_we       = rst_n & mem_we_s;
    assign mem_addr_sel = rst_n & mem_addr_sel_s;
    assign ir_we        = rst_n & ir_we_s;
    assign pc_we        = rst_n & pc_we_s;
    assign pc_src       = rst_n & pc_src_s;
    assign alusrc       = rst_n & alusrc_s;
    assign aluop        = rst_n ? aluop_s : 2'b00;
    assign regwrite     = rst_n & regwrite_s;
    assign memtoreg     = rst_n & memtoreg_s;
    assign retire       = rst_n & retire_s;
    assign trap         = rst_n & trap_s;
    assign trap_cause   = rst_n ? trap_cause_r : TC_NONE;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] instret_r;
    logic [31:0] cycles_r;

    // Retired-instruction and non-trap cycle counters, wrapping at 2**32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_r <= 32'd0;
            cycles_r  <= 32'd0;
        end else begin
            if (retire_s) begin
                instret_r <= instret_r + 32'd1;
            end
            if (state_r != S_TRAP) begin
                cycles_r <= cycles_r + 32'd1;
            end
        end
    end

    assign instret = instret_r;
    assign cycles  = cycles_r;
`endif

endmodule
